// File: rtl/seg7_capture.sv
// Receive side of a multiplexed 7-segment display: synchronises anode/segment lines,
// waits for a stable pattern, decodes it to a nibble per digit and hands out whole frames.
module seg7_capture #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    err,
    output logic [2:0]              err_pos
);

    localparam int CW = $clog2(STABLE_CYC + 2);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

    logic [NUM_DIGITS-1:0]   r_an_meta, r_an_sync, r_an_prev;
    logic [6:0]              r_seg_meta, r_seg_sync, r_seg_prev;
    state_t                  r_state, w_state_next;
    logic [CW-1:0]           r_cnt, w_cnt_next, w_cnt_inc;
    logic [4*NUM_DIGITS-1:0] r_digits, w_digits_next, r_frame_data;
    logic [NUM_DIGITS-1:0]   r_dvalid, w_dvalid_next, r_seen, w_seen_next;
    logic                    r_frame_valid, r_err;
    logic [2:0]              r_err_pos, w_idx;
    logic [NUM_DIGITS-1:0]   w_an_low;
    logic                    w_an_valid, w_sample_chg, w_capture;
    logic                    w_is_blank, w_cap_ok, w_cap_err;
    logic [4:0]              w_dec;

    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0010000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    assign w_an_low     = ~r_an_sync;
    assign w_an_valid   = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
    assign w_sample_chg = {r_an_sync, r_seg_sync} != {r_an_prev, r_seg_prev};
    assign w_cnt_inc    = r_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_an_valid) begin
                    w_state_next = S_SETTLE;
                    w_cnt_next   = CW'(1);
                end
            end
            S_SETTLE: begin
                if (w_sample_chg) begin
                    w_cnt_next   = CW'(1);
                    w_state_next = w_an_valid ? S_SETTLE : S_IDLE;
                end else if (w_cnt_inc >= CW'(STABLE_CYC)) begin
                    w_state_next = S_CAPTURE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_CAPTURE: begin
                w_capture = 1'b1;
                // A change arriving during the capture cycle must not be lost.
                if (w_sample_chg) begin
                    w_cnt_next   = CW'(1);
                    w_state_next = w_an_valid ? S_SETTLE : S_IDLE;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_sample_chg) begin
                    w_cnt_next   = CW'(1);
                    w_state_next = w_an_valid ? S_SETTLE : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The prev registers hold the stable sample while in CAPTURE.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_prev[i]) w_idx = 3'(i);
        end
    end

    assign w_dec      = f_decode(r_seg_prev);
    assign w_is_blank = (r_seg_prev == 7'h7F);
    assign w_cap_ok   = w_capture & (w_dec[4] | w_is_blank);
    assign w_cap_err  = w_capture & ~w_dec[4] & ~w_is_blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            logic w_hit;
            assign w_hit = (w_idx == 3'(gi));
            assign w_digits_next[4*gi +: 4] = (w_capture && w_dec[4] && w_hit) ?
                                              w_dec[3:0] : r_digits[4*gi +: 4];
            assign w_dvalid_next[gi] = (w_cap_ok && w_hit) ? w_dec[4] : r_dvalid[gi];
            assign w_seen_next[gi]   = r_seen[gi] | (w_cap_ok && w_hit);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_meta     <= '1;
            r_an_sync     <= '1;
            r_an_prev     <= '1;
            r_seg_meta    <= '1;
            r_seg_sync    <= '1;
            r_seg_prev    <= '1;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_digits      <= '0;
            r_dvalid      <= '0;
            r_seen        <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_pos     <= 3'd0;
        end else begin
            r_an_meta  <= an;
            r_an_sync  <= r_an_meta;
            r_an_prev  <= r_an_sync;
            r_seg_meta <= seg;
            r_seg_sync <= r_seg_meta;
            r_seg_prev <= r_seg_sync;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_digits   <= w_digits_next;
            r_dvalid   <= w_dvalid_next;
            if (w_cap_err) begin
                r_err     <= 1'b1;
                r_err_pos <= w_idx;
            end
            if (!r_frame_valid && (&w_seen_next)) begin
                r_frame_data  <= w_digits_next;
                r_frame_valid <= 1'b1;
                r_seen        <= '0;
            end else begin
                r_seen <= w_seen_next;
                if (r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_dvalid;
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;
    assign err_pos     = r_err_pos;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scans, glitches, bad anodes, bad patterns,
// frame back-pressure and mid-operation reset.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        err;
    logic [2:0]  err_pos;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          fv_cycles = 0;
    logic [15:0] last_frame = 16'h0;

    localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000,
                           P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010,
                           P7 = 7'b1111000, P8 = 7'b0000000, P9 = 7'b0010000,
                           PA = 7'b0001000, PBLANK = 7'b1111111, PBAD = 7'b1010101;

    seg7_capture #(.NUM_DIGITS(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err         (err),
        .err_pos     (err_pos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) fv_cycles <= fv_cycles + 1;
            if (frame_valid && frame_ready) begin
                xfer_cnt   <= xfer_cnt + 1;
                last_frame <= frame_data;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic hold(input logic [3:0] an_v, input logic [6:0] seg_v, input int n);
        an  = an_v;
        seg = seg_v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_digits"}, 32'(digits), 32'h0);
        check({pfx, "_dvalid"}, 32'(digit_valid), 32'h0);
        check({pfx, "_fdata"},  32'(frame_data), 32'h0);
        check({pfx, "_fvalid"}, 32'(frame_valid), 32'h0);
        check({pfx, "_err"},    32'(err), 32'h0);
        check({pfx, "_errpos"}, 32'(err_pos), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        an = 4'hF;
        seg = PBLANK;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        hold(4'hF, PBLANK, 3);

        // 1: full scan 1,2,3,4 with ready high
        hold(4'b1110, P1, 10);
        hold(4'b1101, P2, 10);
        hold(4'b1011, P3, 10);
        hold(4'b0111, P4, 10);
        hold(4'hF, PBLANK, 5);
        check("scan_digits", 32'(digits), 32'h4321);
        check("scan_dvalid", 32'(digit_valid), 32'hF);
        check("scan_xfers", 32'(xfer_cnt), 32'd1);
        check("scan_frame", 32'(last_frame), 32'h4321);
        check("scan_fv_pulse", 32'(fv_cycles), 32'd1);
        check("scan_fvalid_low", 32'(frame_valid), 32'h0);

        // 2: glitching segments never settle, then a stable A on digit 0
        for (int k = 0; k < 10; k++) hold(4'b1110, (k % 2 == 1) ? P9 : P8, 2);
        hold(4'b1110, PA, 3);
        check("glitch_nocap", 32'(digits), 32'h4321);
        hold(4'b1110, PA, 10);
        check("glitch_then_A", 32'(digits), 32'h432A);
        check("glitch_dvalid", 32'(digit_valid), 32'hF);
        hold(4'hF, PBLANK, 5);

        // 3: two anodes low is ignored
        hold(4'b1100, P8, 20);
        check("twoan_digits", 32'(digits), 32'h432A);
        check("twoan_err", 32'(err), 32'h0);
        check("twoan_xfers", 32'(xfer_cnt), 32'd1);

        // 4: undecodable pattern on digit 2
        hold(4'b1011, PBAD, 10);
        check("bad_err", 32'(err), 32'h1);
        check("bad_errpos", 32'(err_pos), 32'd2);
        check("bad_digits", 32'(digits), 32'h432A);
        check("bad_fvalid", 32'(frame_valid), 32'h0);

        // 5: back-pressure keeps the pending frame stable
        frame_ready = 1'b0;
        hold(4'b1110, P1, 10);
        hold(4'b1101, P2, 10);
        hold(4'b1011, P3, 10);
        hold(4'b0111, P4, 10);
        check("bp_fvalid", 32'(frame_valid), 32'h1);
        check("bp_fdata", 32'(frame_data), 32'h4321);
        hold(4'b1110, P5, 10);
        hold(4'b1101, P6, 10);
        hold(4'b1011, P7, 10);
        hold(4'b0111, P8, 10);
        check("bp_fdata_held", 32'(frame_data), 32'h4321);
        check("bp_live_digits", 32'(digits), 32'h8765);
        check("bp_err_sticky", 32'(err), 32'h1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        check("bp_xfer_clears", 32'(frame_valid), 32'h0);
        @(posedge clk); #1;
        check("bp_next_fvalid", 32'(frame_valid), 32'h1);
        check("bp_next_fdata", 32'(frame_data), 32'h8765);
        check("bp_xfers", 32'(xfer_cnt), 32'd2);
        check("bp_last_frame", 32'(last_frame), 32'h4321);

        // 6: reset while settling with a frame pending
        hold(4'b1110, P1, 4);
        rst = 1'b1;
        an  = 4'hF;
        seg = PBLANK;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_fvalid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        frame_ready = 1'b1;
        hold(4'hF, PBLANK, 3);
        hold(4'b1110, P8, 10);
        hold(4'b1101, P7, 10);
        hold(4'b1011, P6, 10);
        hold(4'b0111, P5, 10);
        hold(4'hF, PBLANK, 5);
        check("resume_digits", 32'(digits), 32'h5678);
        check("resume_xfers", 32'(xfer_cnt), 32'd3);
        check("resume_frame", 32'(last_frame), 32'h5678);

        // blank pattern clears the position's valid flag only
        hold(4'b1101, PBLANK, 10);
        check("blank_dvalid", 32'(digit_valid), 32'b1101);
        check("blank_digits", 32'(digits), 32'h5678);
        check("blank_err", 32'(err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
